decode_issue: RTL
=================

// Module: decode_issue
//
// PURPOSE
//  RV32I ID stage and ID/EX pipeline register for the 5-stage core.
//  - Drives register_file read addresses from the IF/ID instruction.
//  - Generates the immediate and control bits, then captures operands into the ID/EX register.
//  - Detects load-use hazards and inserts a single-cycle bubble.
//  - The register file provides write-first bypass, so same-cycle WB->ID needs no handling here.
//
// PARAMETERS
//  DWIDTH  32  datapath / register width
//  AWIDTH  5   register address width
//
// PORTS
//  clk             in   1       core clock
//  rst             in   1       synchronous active-high reset
//  if_valid_i      in   1       IF/ID holds a valid instruction
//  if_pc_i         in   DWIDTH  PC of the IF/ID instruction
//  if_insn_i       in   32      IF/ID instruction word
//  id_stall_o      out  1       hold PC and IF/ID this cycle
//  rs1_addr_o      out  AWIDTH  to register_file rs1_addr_i
//  rs2_addr_o      out  AWIDTH  to register_file rs2_addr_i
//  rs1_data_i      in   DWIDTH  from register_file rs1_data_o (bypassed)
//  rs2_data_i      in   DWIDTH  from register_file rs2_data_o (bypassed)
//  ex_flush_i      in   1       taken branch/jump redirect from EX
//  ex_stall_i      in   1       downstream stall; hold ID/EX
//  ex_valid_o      out  1       ID/EX entry valid
//  ex_pc_o         out  DWIDTH  registered PC
//  ex_insn_o       out  32      registered instruction
//  ex_rs1_data_o   out  DWIDTH  registered rs1 operand
//  ex_rs2_data_o   out  DWIDTH  registered rs2 operand
//  ex_imm_o        out  DWIDTH  registered sign-extended immediate
//  ex_rd_o         out  AWIDTH  destination register; 0 if no write
//  ex_reg_wen_o    out  1       entry writes rd
//  ex_is_load_o    out  1       entry is a LOAD
//  stall_cnt_o     out  32      load-use bubbles inserted; saturates at 32'hFFFF_FFFF
//
// BEHAVIOUR
//  Reset values (all registered outputs):
//  - ex_valid_o=0, ex_insn_o=32'h0000_0013 (NOP), stall_cnt_o=0.
//  - All other ex_* outputs = 0.
//
//  Combinational outputs:
//  - rs1_addr_o=if_insn_i[19:15], rs2_addr_o=if_insn_i[24:20], unconditional.
//  - id_stall_o = ex_stall_i | (hazard & ~ex_flush_i); forced 0 while rst.
//
//  Decode:
//  - Immediate by opcode: I (OP-IMM, LOAD, JALR), S (STORE), B (BRANCH), U (LUI, AUIPC), J (JAL).
//  - Immediate = 0 for OP and unknown opcodes; always sign-extended from insn[31].
//  - uses_rs1: every opcode except LUI, AUIPC, JAL.
//  - uses_rs2: OP, STORE, BRANCH only.
//  - reg_wen: OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR, and rd!=0. ex_rd_o = reg_wen ? insn[11:7] : 0.
//  - Unknown opcode: issued as valid with reg_wen=0, is_load=0, imm=0.
//
//  hazard = if_valid_i & ex_valid_o & ex_is_load_o & ex_rd_o!=0
//           & ((uses_rs1 & rs1==ex_rd_o) | (uses_rs2 & rs2==ex_rd_o)).
//
//  Posedge update, strict priority:
//  1. rst: load reset values.
//  2. ex_flush_i: write a bubble. Flush beats a simultaneous stall or hazard; stall_cnt unchanged.
//  3. ex_stall_i: hold every ID/EX field; no bubble counted.
//  4. hazard: write a bubble; stall_cnt_o += 1 (saturating).
//  5. otherwise: capture decode results. ex_valid_o = if_valid_i; an invalid input captures as a bubble.
//
//  Bubble: valid=0, reg_wen=0, is_load=0, rd=0, insn=NOP; pc, data and imm = 0.
//  Latency: ID->EX is 1 cycle; a load-use pair costs exactly 1 bubble.
//  x0 is never a hazard source.
//
// STRUCTURE
//  Shared package rv32i_pkg:
//  - opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC)
//  - imm_type_e enum {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE}
//  - NOP_INSN = 32'h0000_0013
//  Sub-module imm_gen: combinational (insn, imm_type) -> DWIDTH immediate.
//  Hazard logic and the ID/EX register stay in this module.
//
// TESTING
//  1. rst=1 for 2 cycles -> ex_valid_o=0, ex_insn_o=0x00000013, id_stall_o=0, stall_cnt_o=0.
//  2. lw x5,0(x1) (0x0000A283) then add x6,x5,x2 (0x00228333)
//     -> id_stall_o=1 for exactly 1 cycle, then a bubble, then add issues with ex_rd_o=6; stall_cnt_o=1.
//  3. lw x5 then lui x6,0x12345 (0x12345337)
//     -> no stall; ex_imm_o=0x12345000, ex_rd_o=6, ex_reg_wen_o=1.
//  4. Load-use hazard with ex_flush_i=1 in the same cycle
//     -> id_stall_o=0, next ex_valid_o=0, stall_cnt_o unchanged.
//  5. ex_stall_i=1 for 3 cycles during issue -> every ex_* output held; id_stall_o=1 throughout.
//  6. beq x1,x2,-4 (0xFE208EE3) -> ex_imm_o=0xFFFFFFFC, ex_reg_wen_o=0, ex_rd_o=0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: base opcodes, immediate formats and the canonical NOP.
package rv32i_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_e;

  // Immediate format implied by the major opcode; OP and unknown opcodes carry none.
  function automatic imm_type_e opcode_imm_type(input logic [6:0] opcode);
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: return IMM_I;
      OPC_STORE:                      return IMM_S;
      OPC_BRANCH:                     return IMM_B;
      OPC_LUI, OPC_AUIPC:             return IMM_U;
      OPC_JAL:                        return IMM_J;
      default:                        return IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator; every format is sign-extended from insn[31].
module imm_gen
  import rv32i_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [31:0]       insn_i,
  input  logic [2:0]        imm_type_i,
  output logic [DWIDTH-1:0] imm_o
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (imm_type_e'(imm_type_i))
      IMM_I: imm32 = {{20{insn_i[31]}}, insn_i[31:20]};
      IMM_S: imm32 = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
      IMM_B: imm32 = {{19{insn_i[31]}}, insn_i[31], insn_i[7], insn_i[30:25],
                      insn_i[11:8], 1'b0};
      IMM_U: imm32 = {insn_i[31:12], 12'b0};
      IMM_J: imm32 = {{11{insn_i[31]}}, insn_i[31], insn_i[19:12], insn_i[20],
                      insn_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    imm_o = DWIDTH'($signed(imm32));
  end

endmodule

// File: rtl/decode_issue.sv
// RV32I decode stage with ID/EX pipeline register, load-use bubble insertion
// and a saturating count of inserted bubbles.
module decode_issue
  import rv32i_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid_i,
  input  logic [DWIDTH-1:0] if_pc_i,
  input  logic [31:0]       if_insn_i,
  output logic              id_stall_o,
  output logic [AWIDTH-1:0] rs1_addr_o,
  output logic [AWIDTH-1:0] rs2_addr_o,
  input  logic [DWIDTH-1:0] rs1_data_i,
  input  logic [DWIDTH-1:0] rs2_data_i,
  input  logic              ex_flush_i,
  input  logic              ex_stall_i,
  output logic              ex_valid_o,
  output logic [DWIDTH-1:0] ex_pc_o,
  output logic [31:0]       ex_insn_o,
  output logic [DWIDTH-1:0] ex_rs1_data_o,
  output logic [DWIDTH-1:0] ex_rs2_data_o,
  output logic [DWIDTH-1:0] ex_imm_o,
  output logic [AWIDTH-1:0] ex_rd_o,
  output logic              ex_reg_wen_o,
  output logic              ex_is_load_o,
  output logic [31:0]       stall_cnt_o
);

  // Flow control: an IF/ID entry advances into ID/EX on a clock edge where
  // id_stall_o is low and no flush is pending; ex_stall_i freezes ID/EX and
  // forces id_stall_o high so IF/ID also holds its instruction.

  logic [6:0]        opcode;
  logic [AWIDTH-1:0] rd_field;
  logic              uses_rs1;
  logic              uses_rs2;
  logic              writes_rd;
  logic              is_load;
  logic              reg_wen;
  logic              hazard;
  imm_type_e         imm_type;
  logic [DWIDTH-1:0] imm;

  logic              ex_valid_q,    ex_valid_d;
  logic [DWIDTH-1:0] ex_pc_q,       ex_pc_d;
  logic [31:0]       ex_insn_q,     ex_insn_d;
  logic [DWIDTH-1:0] ex_rs1_data_q, ex_rs1_data_d;
  logic [DWIDTH-1:0] ex_rs2_data_q, ex_rs2_data_d;
  logic [DWIDTH-1:0] ex_imm_q,      ex_imm_d;
  logic [AWIDTH-1:0] ex_rd_q,       ex_rd_d;
  logic              ex_reg_wen_q,  ex_reg_wen_d;
  logic              ex_is_load_q,  ex_is_load_d;
  logic [31:0]       stall_cnt_q,   stall_cnt_d;

  assign opcode     = if_insn_i[6:0];
  assign rd_field   = AWIDTH'(if_insn_i[11:7]);
  assign rs1_addr_o = AWIDTH'(if_insn_i[19:15]);
  assign rs2_addr_o = AWIDTH'(if_insn_i[24:20]);

  always_comb begin
    uses_rs1  = 1'b1;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    is_load   = 1'b0;
    imm_type  = opcode_imm_type(opcode);
    case (opcode)
      OPC_OP:                 begin uses_rs2 = 1'b1; writes_rd = 1'b1; end
      OPC_OP_IMM, OPC_JALR:   writes_rd = 1'b1;
      OPC_LOAD:               begin writes_rd = 1'b1; is_load = 1'b1; end
      OPC_STORE, OPC_BRANCH:  uses_rs2 = 1'b1;
      OPC_LUI, OPC_AUIPC,
      OPC_JAL:                begin uses_rs1 = 1'b0; writes_rd = 1'b1; end
      default:                ;
    endcase
  end

  assign reg_wen = writes_rd & (rd_field != '0);

  imm_gen #(.DWIDTH(DWIDTH)) u_imm_gen (
    .insn_i     (if_insn_i),
    .imm_type_i (imm_type),
    .imm_o      (imm)
  );

  // ex_rd_q is already 0 for non-writing entries, so x0 never matches here.
  assign hazard = if_valid_i & ex_valid_q & ex_is_load_q & (ex_rd_q != '0) &
                  ((uses_rs1 & (rs1_addr_o == ex_rd_q)) |
                   (uses_rs2 & (rs2_addr_o == ex_rd_q)));

  assign id_stall_o = ~rst & (ex_stall_i | (hazard & ~ex_flush_i));

  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_pc_d       = ex_pc_q;
    ex_insn_d     = ex_insn_q;
    ex_rs1_data_d = ex_rs1_data_q;
    ex_rs2_data_d = ex_rs2_data_q;
    ex_imm_d      = ex_imm_q;
    ex_rd_d       = ex_rd_q;
    ex_reg_wen_d  = ex_reg_wen_q;
    ex_is_load_d  = ex_is_load_q;
    stall_cnt_d   = stall_cnt_q;

    if (!ex_stall_i || ex_flush_i) begin
      if (ex_flush_i || hazard || !if_valid_i) begin
        ex_valid_d    = 1'b0;
        ex_pc_d       = '0;
        ex_insn_d     = NOP_INSN;
        ex_rs1_data_d = '0;
        ex_rs2_data_d = '0;
        ex_imm_d      = '0;
        ex_rd_d       = '0;
        ex_reg_wen_d  = 1'b0;
        ex_is_load_d  = 1'b0;
        if (!ex_flush_i && hazard && (stall_cnt_q != 32'hFFFF_FFFF)) begin
          stall_cnt_d = stall_cnt_q + 32'd1;
        end
      end else begin
        ex_valid_d    = 1'b1;
        ex_pc_d       = if_pc_i;
        ex_insn_d     = if_insn_i;
        ex_rs1_data_d = rs1_data_i;
        ex_rs2_data_d = rs2_data_i;
        ex_imm_d      = imm;
        ex_rd_d       = reg_wen ? rd_field : '0;
        ex_reg_wen_d  = reg_wen;
        ex_is_load_d  = is_load;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= '0;
      ex_insn_q     <= NOP_INSN;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
      ex_imm_q      <= '0;
      ex_rd_q       <= '0;
      ex_reg_wen_q  <= 1'b0;
      ex_is_load_q  <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_pc_q       <= ex_pc_d;
      ex_insn_q     <= ex_insn_d;
      ex_rs1_data_q <= ex_rs1_data_d;
      ex_rs2_data_q <= ex_rs2_data_d;
      ex_imm_q      <= ex_imm_d;
      ex_rd_q       <= ex_rd_d;
      ex_reg_wen_q  <= ex_reg_wen_d;
      ex_is_load_q  <= ex_is_load_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign ex_valid_o    = ex_valid_q;
  assign ex_pc_o       = ex_pc_q;
  assign ex_insn_o     = ex_insn_q;
  assign ex_rs1_data_o = ex_rs1_data_q;
  assign ex_rs2_data_o = ex_rs2_data_q;
  assign ex_imm_o      = ex_imm_q;
  assign ex_rd_o       = ex_rd_q;
  assign ex_reg_wen_o  = ex_reg_wen_q;
  assign ex_is_load_o  = ex_is_load_q;
  assign stall_cnt_o   = stall_cnt_q;

endmodule
